// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM that steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared-memory datapath strobes and selects.
module multicycle_control #(
    parameter int                 OPCODE_W = 6,
    parameter int                 FUNCT_W  = 6,
    parameter int                 ALU_OP_W = 4,
    parameter logic [FUNCT_W-1:0] JR_FUNCT = 6'h08
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_eq_o,
    output logic                pc_write_ne_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          pc_src_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                instr_done_o,
    output logic                illegal_o
);

    localparam logic [4:0] S_INIT     = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_DECODE   = 5'd2;
    localparam logic [4:0] S_R_EXEC   = 5'd3;
    localparam logic [4:0] S_R_WB     = 5'd4;
    localparam logic [4:0] S_I_EXEC   = 5'd5;
    localparam logic [4:0] S_I_WB     = 5'd6;
    localparam logic [4:0] S_MEM_ADDR = 5'd7;
    localparam logic [4:0] S_MEM_RD   = 5'd8;
    localparam logic [4:0] S_MEM_WB   = 5'd9;
    localparam logic [4:0] S_MEM_WR   = 5'd10;
    localparam logic [4:0] S_BEQ      = 5'd11;
    localparam logic [4:0] S_BNE      = 5'd12;
    localparam logic [4:0] S_JUMP     = 5'd13;
    localparam logic [4:0] S_JAL      = 5'd14;
    localparam logic [4:0] S_JR       = 5'd15;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'h03);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'h0C);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'h0D);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'h0F);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);

    localparam logic [3:0] ALU_ORI  = 4'd1;
    localparam logic [3:0] ALU_LUI  = 4'd2;
    localparam logic [3:0] ALU_ANDI = 4'd3;
    localparam logic [3:0] ALU_ADD  = 4'd4;
    localparam logic [3:0] ALU_MEM  = 4'd5;
    localparam logic [3:0] ALU_BEQ  = 4'd6;
    localparam logic [3:0] ALU_R    = 4'd7;
    localparam logic [3:0] ALU_BNE  = 4'd8;

    logic [4:0] state_q;
    logic [4:0] state_d;
    logic [3:0] i_alu_q;
    logic [3:0] i_alu_d;
    logic [3:0] alu_code_s;

    // S_FETCH from DECODE means "unsupported opcode"; the illegal flag keys off it.
    function automatic logic [4:0] decode_target(input logic [OPCODE_W-1:0] op,
                                                 input logic [FUNCT_W-1:0]  fn);
        logic [4:0] tgt;
        case (op)
            OP_RTYPE: begin
                if (fn == JR_FUNCT) begin
                    tgt = S_JR;
                end else begin
                    tgt = S_R_EXEC;
                end
            end
            OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: tgt = S_I_EXEC;
            OP_LW, OP_SW:                     tgt = S_MEM_ADDR;
            OP_BEQ:                           tgt = S_BEQ;
            OP_BNE:                           tgt = S_BNE;
            OP_J:                             tgt = S_JUMP;
            OP_JAL:                           tgt = S_JAL;
            default:                          tgt = S_FETCH;
        endcase
        return tgt;
    endfunction

    function automatic logic [3:0] i_alu_code(input logic [OPCODE_W-1:0] op);
        logic [3:0] code;
        case (op)
            OP_ADDI: code = ALU_ADD;
            OP_ORI:  code = ALU_ORI;
            OP_LUI:  code = ALU_LUI;
            OP_ANDI: code = ALU_ANDI;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // State register and I-type ALU code captured at DECODE, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            i_alu_q <= 4'd0;
        end else begin
            state_q <= state_d;
            i_alu_q <= i_alu_d;
        end
    end

    // I-type ALU code so I_EXEC drives alu_op from registered state only.
    always_comb begin
        if (state_q == S_DECODE) begin
            i_alu_d = i_alu_code(opcode_i);
        end else begin
            i_alu_d = i_alu_q;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready_i.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: state_d = decode_target(opcode_i, funct_i);
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
            S_MEM_ADDR: begin
                if (opcode_i == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            default:  state_d = S_INIT;
        endcase
    end

    // Moore output decode; FETCH/MEM_WR gate strobes on mem_ready_i, DECODE flags illegal opcodes.
    always_comb begin
        pc_write_o    = 1'b0;
        pc_write_eq_o = 1'b0;
        pc_write_ne_o = 1'b0;
        i_or_d_o      = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        reg_dst_o     = 2'd0;
        mem_to_reg_o  = 2'd0;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'd0;
        pc_src_o      = 2'd0;
        alu_code_s    = 4'd0;
        instr_done_o  = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_code_s  = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_code_s  = ALU_ADD;
                illegal_o   = (decode_target(opcode_i, funct_i) == S_FETCH);
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_code_s  = ALU_R;
            end
            S_R_WB: begin
                reg_dst_o    = 2'd1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_code_s  = i_alu_q;
            end
            S_I_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_code_s  = ALU_MEM;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg_o = 2'd1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_BEQ: begin
                alu_src_a_o   = 1'b1;
                alu_code_s    = ALU_BEQ;
                pc_src_o      = 2'd1;
                pc_write_eq_o = 1'b1;
                instr_done_o  = 1'b1;
            end
            S_BNE: begin
                alu_src_a_o   = 1'b1;
                alu_code_s    = ALU_BNE;
                pc_src_o      = 2'd1;
                pc_write_ne_o = 1'b1;
                instr_done_o  = 1'b1;
            end
            S_JUMP: begin
                pc_src_o     = 2'd2;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_JAL: begin
                reg_dst_o    = 2'd2;
                mem_to_reg_o = 2'd2;
                reg_write_o  = 1'b1;
                pc_src_o     = 2'd2;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_JR: begin
                pc_src_o     = 2'd3;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            default: begin
                alu_code_s = 4'd0;
            end
        endcase
        alu_op_o = ALU_OP_W'(alu_code_s);
    end

endmodule
